// File: rtl/fetch_branch_unit_if.sv
// fetch_branch_unit_if: decode-side inputs and fetch/status outputs of the fetch/branch unit
interface fetch_branch_unit_if #(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 5
);
  logic              exec;
  logic              stall;
  logic              dec_valid;
  logic [15:0]       dec_ir;
  logic [ADDR_W-1:0] dec_pc;
  logic [3:0]        szcv;
  logic              halt_req;
  logic [ADDR_W-1:0] pc;
  logic              fetch_en;
  logic              flush;
  logic              halting;
  logic [CNT_W-1:0]  ras_count;
  logic              ras_ovf;
  logic              ras_unf;
  modport master (
    output exec, stall, dec_valid, dec_ir, dec_pc, szcv, halt_req,
    input  pc, fetch_en, flush, halting, ras_count, ras_ovf, ras_unf
  );
  modport slave (
    input  exec, stall, dec_valid, dec_ir, dec_pc, szcv, halt_req,
    output pc, fetch_en, flush, halting, ras_count, ras_ovf, ras_unf
  );
endinterface

// File: rtl/fetch_branch_unit.sv
// fetch_branch_unit: fetch PC, branch resolution for P2, return-address stack and run/halt control
module fetch_branch_unit #(
  parameter int ADDR_W    = 12,
  parameter int RAS_DEPTH = 16,
  parameter int CNT_W     = $clog2(RAS_DEPTH + 1)
) (
  input  logic               clock,
  input  logic               reset,
  fetch_branch_unit_if.slave bus
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_HALT = 2'd2;
  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_flush, r_ovf, r_unf;
  logic [CNT_W-1:0]  r_count;
  logic [PW-1:0]     r_top;
  logic [ADDR_W-1:0] r_ras [RAS_DEPTH];
  logic              w_run, w_acc, w_b, w_bal, w_br, w_bcc, w_sv, w_cc;
  logic              w_empty, w_full, w_push, w_pop, w_redir, w_halt, w_unused_c;
  logic [ADDR_W-1:0] w_disp, w_tgt;
  logic [PW-1:0]     w_top_up;
  assign w_run    = r_state == S_RUN;
  assign w_acc    = w_run & bus.dec_valid & ~bus.stall & ~r_flush;
  assign w_b      = bus.dec_ir[15:11] == 5'b10100;
  assign w_bal    = bus.dec_ir[15:11] == 5'b10110;
  assign w_br     = bus.dec_ir[15:11] == 5'b10101;
  assign w_bcc    = bus.dec_ir[15:10] == 6'b101110;
  assign w_sv     = bus.szcv[3] ^ bus.szcv[0];
  assign w_cc     = bus.dec_ir[9] ? (bus.dec_ir[8] ? ~bus.szcv[2] : bus.szcv[2] | w_sv)
                                  : (bus.dec_ir[8] ? w_sv : bus.szcv[2]);
  assign w_unused_c = bus.szcv[1];
  assign w_empty  = r_count == '0;
  assign w_full   = r_count == CNT_W'(RAS_DEPTH);
  assign w_push   = w_acc & w_bal;
  assign w_redir  = w_acc & (w_b | w_bal | (w_bcc & w_cc) | (w_br & ~w_empty));
  assign w_pop    = w_redir & w_br;
  // a BR that cannot redirect is an underflow and halts like HLT
  assign w_halt   = w_acc & ~w_redir & (bus.halt_req | w_br);
  assign w_disp   = {{(ADDR_W-8){bus.dec_ir[7]}}, bus.dec_ir[7:0]};
  assign w_tgt    = w_br ? r_ras[r_top] : bus.dec_pc + w_disp;
  assign w_top_up = r_top + PW'(1);
  // circular buffer: pushing when full naturally overwrites the oldest slot
  always_ff @(posedge clock)
    if (w_push) r_ras[w_top_up] <= bus.dec_pc + ADDR_W'(1);
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_flush <= 1'b0;
      r_count <= '0;
      r_top   <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (w_run) begin
      if (w_redir) begin
        r_pc    <= w_tgt;
        r_flush <= 1'b1;
      end else if (w_halt) begin
        r_state <= S_HALT;
      end else if (!bus.stall) begin
        r_pc    <= r_pc + ADDR_W'(1);
        r_flush <= 1'b0;
      end
      if (w_push) begin
        r_top   <= w_top_up;
        r_count <= w_full ? r_count : r_count + CNT_W'(1);
        r_ovf   <= r_ovf | w_full;
      end
      if (w_pop) begin
        r_top   <= r_top - PW'(1);
        r_count <= r_count - CNT_W'(1);
      end
      if (w_halt & w_br) r_unf <= 1'b1;
    end else if (bus.exec) begin
      r_state <= S_RUN;
    end
  end
  assign bus.pc        = r_pc;
  assign bus.fetch_en  = w_run;
  assign bus.flush     = r_flush;
  assign bus.halting   = r_state == S_HALT;
  assign bus.ras_count = r_count;
  assign bus.ras_ovf   = r_ovf;
  assign bus.ras_unf   = r_unf;
endmodule

// File: doc/fetch_branch_unit.md
Name: fetch_branch_unit

Overview:
- Parametrised successor to the processor's inline PC and branch logic. It holds the fetch PC and resolves B/BAL/BR and conditional branches for the instruction in decode (P2).
- Drives the flush to P1/P2 and owns a return-address stack (RAS) of configurable depth, with overflow and underflow detection.
- Adds a run/halt state machine with exec-driven start and resume.
- Sits between instruction memory addressing and the P2 pipeline register.

Parameters:
- ADDR_W, 12: width of PC, dec_pc and branch target; instruction memory address width.
- RAS_DEPTH, 16: return-address stack entries; power of two, 2..256.
- CNT_W, $clog2(RAS_DEPTH+1): width of ras_count.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- exec  in  1  start/resume pulse
- stall  in  1  load-use hazard from hazard detection; freezes PC and RAS
- dec_valid  in  1  P2 holds a real (non-bubble) instruction
- dec_ir  in  16  P2 instruction word
- dec_pc  in  ADDR_W  address of P2 instruction
- szcv  in  4  flags for P2 branch: [3]S [2]Z [1]C [0]V
- halt_req  in  1  P2 instruction is HLT (from controller)
- pc  out  ADDR_W  fetch address to instruction memory
- fetch_en  out  1  high in RUN; P1 captures only when high
- flush  out  1  squash P1/P2 this cycle
- halting  out  1  high in HALT
- ras_count  out  CNT_W  valid RAS entries
- ras_ovf  out  1  sticky: push onto full RAS occurred
- ras_unf  out  1  sticky: BR with empty RAS occurred

Behaviour:
- Reset (sync): pc=0, state=IDLE, flush=0, halting=0, fetch_en=0, ras_count=0, ras_ovf=0, ras_unf=0. Reset overrides every other input in the same cycle, including mid-branch or mid-stall. RAS contents are don't-care after reset.
- States: IDLE, RUN, HALT.
  - IDLE -> RUN on exec.
  - RUN -> HALT on accepted halt_req or on RAS underflow.
  - HALT -> RUN on exec; pc resumes from its frozen value.
  - exec is ignored in RUN.
- fetch_en = (state==RUN). halting = (state==HALT). Both are registered outputs.
- Accept condition: acc = RUN & dec_valid & ~stall & ~flush. Instructions presented while flush=1 are wrong-path and are never evaluated.
- Decode on dec_ir (D = sign-extended dec_ir[7:0] to ADDR_W; target = dec_pc + D, modulo 2^ADDR_W):
  - [15:11]=10100 B: always taken.
  - [15:11]=10110 BAL: taken; push dec_pc+1.
  - [15:11]=10101 BR: pop; target = top entry.
  - [15:8]=10111000 BE, taken if Z.
  - [15:8]=10111001 BLT, taken if S^V.
  - [15:8]=10111010 BLE, taken if Z|(S^V).
  - [15:8]=10111011 BNE, taken if ~Z.
  - [15:8]=101111xx: never taken; behaves as non-branch.
- Priority when acc: taken branch / BAL / BR redirect > halt_req > sequential.
  - Redirect: pc<=target at the next edge. flush<=1 for exactly one cycle, i.e. the cycle after the redirect edge.
  - Halt: pc holds, state<=HALT, flush=0.
  - Sequential: pc<=pc+1, wrapping at 2^ADDR_W.
- If RUN and not acc:
  - stall=1: pc, RAS and flush all hold.
  - otherwise (bubble or flush cycle): pc<=pc+1, and flush<=0.
- Consecutive redirects are impossible: the instruction following a redirect is always squashed.
- RAS is a circular buffer with top pointer.
  - Push when full: overwrite the oldest entry, ras_count stays RAS_DEPTH, set ras_ovf.
  - Pop when non-empty: ras_count-1.
  - Pop when empty: no redirect, pc holds, state<=HALT, set ras_unf, flush=0.
- Sticky flags clear only on reset.
- IDLE/HALT: pc, RAS, flush=0 all held; dec_* inputs ignored.

Test Plan:
- Reset, exec pulse, dec_valid=0 for 4 cycles -> pc 0,1,2,3,4; fetch_en=1 from cycle after exec; flush=0 throughout.
- dec_ir=0xA005 (B +5), dec_pc=0x010 -> next pc=0x015; flush=1 one cycle; a BE presented during the flush cycle is ignored.
- dec_ir=0xB8FE (BE -2), dec_pc=0x020:
  - szcv=0100 -> pc=0x01E.
  - szcv=0000 -> pc increments.
  - BLT (0xB903) with S=1,V=0 -> taken.
- BAL 0xB004 at dec_pc=0x030 -> pc=0x034, ras_count=1. Later BR 0xA800 -> pc=0x031, ras_count=0.
- RAS_DEPTH=4, five nested BALs (dec_pc 0x40..0x44) -> ras_ovf=1, ras_count=4.
  - Four BRs return 0x45,0x44,0x43,0x42.
  - Fifth BR -> halting=1, ras_unf=1, pc frozen.
- stall=1 held 2 cycles with a taken B in P2 -> pc unchanged, no flush; redirect occurs on first cycle after stall drops.
- halt_req accepted -> HALT, pc frozen.
  - exec -> RUN, pc continues +1.
  - reset asserted in same cycle as a taken branch -> pc=0, IDLE, flush=0.
